// File: rtl/zap_branch_predict_ctrl_if.sv
// Predictor control bundle: fetch request/prediction, resolution, RAM ports, busy.
// slave  : the predictor control stage
// master : the surrounding pipeline / RAM environment
interface zap_branch_predict_ctrl_if #(
  parameter int NUMBER_OF_ENTRIES = 64
) ();
  localparam int IDX = $clog2(NUMBER_OF_ENTRIES);

  logic           i_clear;
  logic           i_fetch_valid;
  logic           i_fetch_stall;
  logic [31:0]    i_fetch_pc;
  logic           o_pred_valid;
  logic           o_pred_taken;
  logic [1:0]     o_pred_state;
  logic           i_res_valid;
  logic [31:0]    i_res_pc;
  logic [1:0]     i_res_state;
  logic           i_res_taken;
  logic [IDX-1:0] o_ram_rd_addr;
  logic [1:0]     i_ram_rd_data;
  logic           o_ram_wr_en;
  logic [IDX-1:0] o_ram_wr_addr;
  logic [1:0]     o_ram_wr_data;
  logic           o_busy;

  modport slave (
    input  i_clear, i_fetch_valid, i_fetch_stall, i_fetch_pc,
    input  i_res_valid, i_res_pc, i_res_state, i_res_taken,
    input  i_ram_rd_data,
    output o_pred_valid, o_pred_taken, o_pred_state,
    output o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
    output o_busy
  );

  modport master (
    output i_clear, i_fetch_valid, i_fetch_stall, i_fetch_pc,
    output i_res_valid, i_res_pc, i_res_state, i_res_taken,
    output i_ram_rd_data,
    input  o_pred_valid, o_pred_taken, o_pred_state,
    input  o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data,
    input  o_busy
  );
endinterface

// File: rtl/zap_branch_predict_ctrl.sv
// Branch predictor control stage around a registered-read predictor RAM.
// Fetch side turns the fetch PC into a RAM index and presents the returned
// 2-bit counter one cycle later; resolution side writes back the saturating
// counter update; a clear sequencer zeroes the whole RAM after reset / flush.
//
// Build option: define ZAP_BP_WRITE_BYPASS_EN to forward a same-cycle RAM write
// into the prediction when it hits the index being read (otherwise the
// prediction shows the pre-write counter).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing 00 to entry clr_cnt each cycle; predictions suppressed
// ST_RUN   | normal fetch prediction and resolution updates
module zap_branch_predict_ctrl #(
  parameter int NUMBER_OF_ENTRIES = 64,
  parameter int ENTRY_SIZE        = 2
) (
  input logic                     i_clk,
  input logic                     i_reset,
  zap_branch_predict_ctrl_if.slave bp
);

  localparam int IDX = $clog2(NUMBER_OF_ENTRIES);
  localparam logic [IDX-1:0]        LAST_IDX = IDX'(NUMBER_OF_ENTRIES - 1);
  localparam logic [ENTRY_SIZE-1:0] CTR_MAX  = '1;
  localparam logic [ENTRY_SIZE-1:0] CTR_MIN  = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX-1:0]        clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic [IDX-1:0]        rd_idx_q, rd_idx_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_fresh_q, pred_fresh_d;
  logic [ENTRY_SIZE-1:0] pred_state_q, pred_state_d;
  logic                  wr_en_q, wr_en_d;
  logic [IDX-1:0]        wr_addr_q, wr_addr_d;
  logic [ENTRY_SIZE-1:0] wr_data_q, wr_data_d;
  logic                  byp_hit_q, byp_hit_d;
  logic [ENTRY_SIZE-1:0] byp_data_q, byp_data_d;

  logic                  fetch_issue;
  logic [IDX-1:0]        fetch_idx;
  logic [IDX-1:0]        res_idx;
  logic [IDX-1:0]        rd_addr;
  logic [ENTRY_SIZE-1:0] pred_state_out;
  logic                  unused_pc_bits;

  function automatic logic [ENTRY_SIZE-1:0] ctr_next(
    input logic [ENTRY_SIZE-1:0] s,
    input logic                  taken
  );
    if (taken) begin
      return (s == CTR_MAX) ? s : s + ENTRY_SIZE'(1);
    end
    return (s == CTR_MIN) ? s : s - ENTRY_SIZE'(1);
  endfunction

  assign fetch_idx      = bp.i_fetch_pc[IDX+1:2];
  assign res_idx        = bp.i_res_pc[IDX+1:2];
  assign fetch_issue    = bp.i_fetch_valid & ~bp.i_fetch_stall;
  assign unused_pc_bits = ^{bp.i_fetch_pc[31:IDX+2], bp.i_fetch_pc[1:0],
                            bp.i_res_pc[31:IDX+2], bp.i_res_pc[1:0]};

  // Read index: a new fetch issues its index, otherwise re-read the last one so
  // the RAM output stays put while fetch is stalled.
  always_comb begin
    rd_addr = rd_idx_q;
    if (fetch_issue) begin
      rd_addr = fetch_idx;
    end
  end

  // Prediction value: fresh RAM (or forwarded write) data in the cycle after an
  // issue, otherwise the held copy so stalls cannot disturb it.
  always_comb begin
    pred_state_out = pred_state_q;
    if (pred_fresh_q) begin
      pred_state_out = byp_hit_q ? byp_data_q : bp.i_ram_rd_data;
    end
  end

  assign bp.o_ram_rd_addr = rd_addr;
  assign bp.o_pred_valid  = pred_valid_q;
  assign bp.o_pred_state  = pred_state_out;
  assign bp.o_pred_taken  = pred_state_out[ENTRY_SIZE-1];
  assign bp.o_ram_wr_en   = wr_en_q;
  assign bp.o_ram_wr_addr = wr_addr_q;
  assign bp.o_ram_wr_data = wr_data_q;
  assign bp.o_busy        = busy_q;

  // Next-state: clear sequencer, resolution write-back and prediction pipe.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    rd_idx_d     = rd_addr;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    pred_valid_d = 1'b0;
    pred_fresh_d = 1'b0;
    pred_state_d = pred_state_out;

    if (bp.i_clear) begin
      // A flush restarts the sweep and drops any resolution in the same cycle.
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q;
          wr_data_d = CTR_MIN;
          clr_cnt_d = clr_cnt_q + IDX'(1);
          if (clr_cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bp.i_res_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = res_idx;
            wr_data_d = ctr_next(bp.i_res_state, bp.i_res_taken);
          end
          pred_valid_d = bp.i_fetch_stall ? pred_valid_q : bp.i_fetch_valid;
          pred_fresh_d = fetch_issue;
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end

    busy_d = (state_d == ST_CLEAR);
  end

  // Write-to-read forwarding: capture a write that lands on the index being read.
  always_comb begin
`ifdef ZAP_BP_WRITE_BYPASS_EN
    byp_hit_d  = wr_en_q && (wr_addr_q == rd_addr);
    byp_data_d = wr_data_q;
`else
    byp_hit_d  = 1'b0;
    byp_data_d = '0;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
      rd_idx_q     <= '0;
      pred_valid_q <= 1'b0;
      pred_fresh_q <= 1'b0;
      pred_state_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byp_hit_q    <= 1'b0;
      byp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_q       <= busy_d;
      rd_idx_q     <= rd_idx_d;
      pred_valid_q <= pred_valid_d;
      pred_fresh_q <= pred_fresh_d;
      pred_state_q <= pred_state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byp_hit_q    <= byp_hit_d;
      byp_data_q   <= byp_data_d;
    end
  end

endmodule

// File: tb/tb_zap_branch_predict_ctrl.sv
// Bench for zap_branch_predict_ctrl: RAM environment, behavioural predictor
// model compared every cycle, directed literal scenarios plus random traffic.
module tb_zap_branch_predict_ctrl;
  localparam int N   = 64;
  localparam int IDX = 6;
`ifdef ZAP_BP_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  zap_branch_predict_ctrl_if #(.NUMBER_OF_ENTRIES(N)) bp ();

  zap_branch_predict_ctrl #(.NUMBER_OF_ENTRIES(N), .ENTRY_SIZE(2)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bp     (bp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] garb(input int i);
    return 2'((i * 5 + 3) >> 1);
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[IDX+1:2]);
  endfunction

  function automatic int sat_next(input int s, input bit t);
    if (t) return (s >= 3) ? 3 : s + 1;
    return (s <= 0) ? 0 : s - 1;
  endfunction

  function automatic logic [31:0] pc_for(input int i);
    return ($urandom() & 32'hFFFF_FF03) | (32'(i) << 2);
  endfunction

  // ---------------- predictor RAM: registered read, old data on collision
  logic [1:0] mem [N];
  bit ram_init = 1'b0;
  always @(posedge i_clk) begin
    if (!ram_init) begin
      for (int i = 0; i < N; i++) mem[i] <= garb(i);
      bp.i_ram_rd_data <= 2'b00;
      ram_init <= 1'b1;
    end else begin
      bp.i_ram_rd_data <= mem[bp.o_ram_rd_addr];
      if (bp.o_ram_wr_en) mem[bp.o_ram_wr_addr] <= bp.o_ram_wr_data;
    end
  end

  // ---------------- behavioural model: expected outputs for the coming cycle
  int         m_clear_left, m_clear_next;
  bit         m_wr_en;
  int         m_wr_addr, m_wr_data;
  bit         m_valid;
  int         m_state;
  int         m_held;
  logic [1:0] shadow [N];
  int         ra;
  int         pre_v, post_v;
  bit         in_clear;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_clear_left = N; m_clear_next = 0;
      m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
      m_valid = 0; m_state = 0; m_held = 0;
      for (int i = 0; i < N; i++) shadow[i] = garb(i);
    end else begin
      in_clear = (m_clear_left > 0);
      ra = (bp.i_fetch_valid && !bp.i_fetch_stall) ? idx_of(bp.i_fetch_pc) : m_held;
      m_held = ra;
      pre_v = shadow[ra];
      if (m_wr_en) shadow[m_wr_addr] = 2'(m_wr_data);
      post_v = shadow[ra];

      if (bp.i_clear || in_clear) m_valid = 0;
      else if (!bp.i_fetch_stall) begin
        m_valid = bp.i_fetch_valid;
        if (bp.i_fetch_valid) m_state = BYPASS ? post_v : pre_v;
      end

      if (bp.i_clear) begin
        m_clear_left = N; m_clear_next = 0; m_wr_en = 0;
      end else if (in_clear) begin
        m_wr_en = 1; m_wr_addr = m_clear_next; m_wr_data = 0;
        m_clear_next++; m_clear_left--;
      end else begin
        m_wr_en = bp.i_res_valid;
        if (bp.i_res_valid) begin
          m_wr_addr = idx_of(bp.i_res_pc);
          m_wr_data = sat_next(int'(bp.i_res_state), bp.i_res_taken);
        end
      end
    end
  end

  // ---------------- compare process
  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("busy", bp.o_busy, (m_clear_left > 0) ? 1 : 0);
      check("wr_en", bp.o_ram_wr_en, m_wr_en);
      if (m_wr_en) begin
        check("wr_addr", bp.o_ram_wr_addr, m_wr_addr);
        check("wr_data", bp.o_ram_wr_data, m_wr_data);
      end
      check("pred_valid", bp.o_pred_valid, m_valid);
      if (m_valid) begin
        check("pred_state", bp.o_pred_state, m_state);
        check("pred_taken", bp.o_pred_taken, m_state / 2);
      end
      check("rd_addr", bp.o_ram_rd_addr,
            (bp.i_fetch_valid && !bp.i_fetch_stall) ? idx_of(bp.i_fetch_pc) : m_held);
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bp.i_clear = 0; bp.i_fetch_valid = 0; bp.i_fetch_stall = 0; bp.i_fetch_pc = 0;
    bp.i_res_valid = 0; bp.i_res_pc = 0; bp.i_res_state = 0; bp.i_res_taken = 0;
  endtask

  // Follows one full clear sweep from its first busy cycle.
  task automatic run_clear();
    int n_busy, n_wr, n_order, n_pv;
    n_busy = 0; n_wr = 0; n_order = 0; n_pv = 0;
    for (int k = 0; k < 200; k++) begin
      if (!bp.o_busy) break;
      n_busy++;
      if (bp.o_pred_valid) n_pv++;
      tick();
      if (bp.o_ram_wr_en) begin
        if (int'(bp.o_ram_wr_addr) != n_wr || bp.o_ram_wr_data != 2'b00) n_order++;
        n_wr++;
      end
    end
    check("clear_busy_cycles", n_busy, 64);
    check("clear_write_count", n_wr, 64);
    check("clear_write_order", n_order, 0);
    check("valid_while_busy", n_pv, 0);
  endtask

  int st_tab [8] = '{0, 1, 2, 3, 0, 3, 1, 2};
  int tk_tab [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
  int ex_tab [8] = '{1, 2, 3, 3, 0, 2, 0, 3};
  int sel;

  initial begin
    idle();
    i_reset = 1;
    repeat (3) tick();
    check("reset_busy", bp.o_busy, 1);
    check("reset_pred_valid", bp.o_pred_valid, 0);
    check("reset_pred_state", bp.o_pred_state, 0);
    check("reset_wr_en", bp.o_ram_wr_en, 0);
    check("reset_wr_addr", bp.o_ram_wr_addr, 0);
    check("reset_wr_data", bp.o_ram_wr_data, 0);
    i_reset = 0;

    // clear after reset, with fetches offered that must be ignored
    bp.i_fetch_valid = 1; bp.i_fetch_pc = 32'h0000_0040;
    run_clear();
    bp.i_fetch_valid = 0;

    // first fetch after clear
    bp.i_fetch_valid = 1; bp.i_fetch_pc = 32'h0000_0100;
    #1;
    check("fetch_0x100_rd_addr", bp.o_ram_rd_addr, 0);
    tick();
    bp.i_fetch_valid = 0;
    check("fetch_0x100_valid", bp.o_pred_valid, 1);
    check("fetch_0x100_state", bp.o_pred_state, 0);
    check("fetch_0x100_taken", bp.o_pred_taken, 0);

    // back-to-back resolutions on idx 1, saturating in both directions
    for (int r = 0; r < 8; r++) begin
      bp.i_res_valid = 1; bp.i_res_pc = 32'h0000_0104;
      bp.i_res_state = 2'(st_tab[r]); bp.i_res_taken = tk_tab[r][0];
      tick();
      check("res_wr_en", bp.o_ram_wr_en, 1);
      check("res_wr_addr", bp.o_ram_wr_addr, 1);
      check("res_wr_data", bp.o_ram_wr_data, ex_tab[r]);
    end
    bp.i_res_valid = 0;
    tick();
    check("res_idle_wr_en", bp.o_ram_wr_en, 0);

    // stall holds read index and prediction
    bp.i_fetch_valid = 1; bp.i_fetch_pc = 32'h0000_0104;
    tick();
    check("stall_first_state", bp.o_pred_state, 3);
    bp.i_fetch_stall = 1; bp.i_fetch_pc = 32'h0000_0200;
    #1;
    for (int s = 0; s < 3; s++) begin
      check("stall_rd_addr", bp.o_ram_rd_addr, 1);
      tick();
      check("stall_pred_valid", bp.o_pred_valid, 1);
      check("stall_pred_state", bp.o_pred_state, 3);
    end
    bp.i_fetch_stall = 0; bp.i_fetch_valid = 0;
    tick();

    // fetch of idx 2 in the very cycle its update is written
    bp.i_res_valid = 1; bp.i_res_pc = 32'h0000_0108; bp.i_res_state = 2'b01; bp.i_res_taken = 1;
    tick();
    bp.i_res_valid = 0;
    bp.i_fetch_valid = 1; bp.i_fetch_pc = 32'h0000_0108;
    check("collide_wr_addr", bp.o_ram_wr_addr, 2);
    tick();
    bp.i_fetch_valid = 0;
    check("collide_valid", bp.o_pred_valid, 1);
    check("collide_state", bp.o_pred_state, BYPASS ? 2 : 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      bp.i_clear       = ($urandom_range(0, 299) == 0);
      bp.i_fetch_valid = ($urandom_range(0, 9) < 7);
      bp.i_fetch_stall = ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      bp.i_fetch_pc    = pc_for(sel);
      bp.i_res_valid   = ($urandom_range(0, 1) == 1);
      sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      bp.i_res_pc      = pc_for(sel);
      bp.i_res_state   = 2'($urandom_range(0, 3));
      bp.i_res_taken   = $urandom_range(0, 1) == 1;
      tick();
    end
    idle();
    for (int k = 0; k < 100 && bp.o_busy; k++) tick();
    check("random_end_idle", bp.o_busy, 0);

    // flush in RUN together with a resolution
    bp.i_clear = 1;
    bp.i_res_valid = 1; bp.i_res_pc = 32'h0000_010C; bp.i_res_state = 2'b00; bp.i_res_taken = 1;
    tick();
    idle();
    check("flush_busy_next", bp.o_busy, 1);
    check("flush_drops_res", bp.o_ram_wr_en, 0);
    run_clear();

    // every entry reads back 00
    for (int i = 0; i < N; i++) begin
      bp.i_fetch_valid = 1; bp.i_fetch_pc = pc_for(i);
      tick();
      check("after_flush_valid", bp.o_pred_valid, 1);
      check("after_flush_state", bp.o_pred_state, 0);
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zap_branch_predict_ctrl.md
Name: zap_branch_predict_ctrl

Overview:
- Control stage wrapped around the branch predictor RAM.
- Fetch side: derives the RAM read index from the fetch PC and aligns the registered RAM output with the fetched instruction as a taken/not-taken prediction.
- Resolution side: applies the 2-bit saturating-counter update from execute-stage branch outcomes and drives the RAM write port.
- Owns a clear sequencer that zeroes every RAM entry after reset or on a flush request.

Parameters:
- NUMBER_OF_ENTRIES, 64, predictor entries; power of two, >= 4; IDX = $clog2(NUMBER_OF_ENTRIES).
- ENTRY_SIZE, 2, counter width; fixed at 2; other values unsupported.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  one-cycle pulse; flush predictor (context switch).
- i_fetch_valid  in  1  fetch PC valid this cycle.
- i_fetch_stall  in  1  fetch stage stalled; hold prediction outputs.
- i_fetch_pc  in  32  fetch PC.
- o_pred_valid  out  1  prediction valid; aligned one cycle after the accepted fetch.
- o_pred_taken  out  1  predicted taken (= o_pred_state[1]).
- o_pred_state  out  2  counter value, carried down the pipe for the update.
- i_res_valid  in  1  branch resolved this cycle.
- i_res_pc  in  32  PC of the resolved branch.
- i_res_state  in  2  counter value the branch was predicted with.
- i_res_taken  in  1  actual outcome.
- o_ram_rd_addr  out  IDX  RAM read index.
- i_ram_rd_data  in  2  RAM registered read data.
- o_ram_wr_en  out  1  RAM write enable.
- o_ram_wr_addr  out  IDX  RAM write index.
- o_ram_wr_data  out  2  RAM write data.
- o_busy  out  1  clear sequence in progress.

Behaviour:
- Index: idx(pc) = pc[IDX+1:2].
- Reset: state = CLEAR; clear counter = 0; o_busy = 1; o_pred_valid = 0; o_pred_taken = 0; o_pred_state = 0; o_ram_wr_en = 0; o_ram_wr_addr = 0; o_ram_wr_data = 0; held read index = 0.
- Clear sequencer, state CLEAR:
  - Each cycle drive o_ram_wr_en = 1, o_ram_wr_addr = counter, o_ram_wr_data = 2'b00, then counter++.
  - After writing entry N-1, go to RUN and deassert o_busy. A full clear occupies exactly N cycles of writes.
  - i_res_valid is ignored in CLEAR; o_pred_valid is forced to 0.
  - i_clear in CLEAR restarts the counter at 0.
- i_clear in RUN: next cycle enter CLEAR with counter = 0. Any resolution presented in the same cycle as i_clear is dropped.
- Fetch path (RUN):
  - o_ram_rd_addr = idx(i_fetch_pc) when i_fetch_valid && !i_fetch_stall; otherwise it holds the last issued index, so RAM data is stable under stall.
  - Registered outputs: o_pred_valid <= issued-valid; o_pred_state <= i_ram_rd_data at the aligned cycle.
  - While i_fetch_stall = 1, o_pred_* hold their values.
  - Latency: PC in cycle T -> prediction in cycle T+1.
- Update path (RUN), registered one cycle: i_res_valid in T -> o_ram_wr_en = 1 in T+1, with o_ram_wr_addr = idx(i_res_pc) and o_ram_wr_data = next(i_res_state, i_res_taken).
  - Taken: 00->01->10->11->11 (saturate at 11).
  - Not taken: 11->10->01->00->00 (saturate at 00).
  - No i_res_valid -> o_ram_wr_en = 0 the next cycle.
- Back-to-back resolutions are accepted every cycle; no queueing and no backpressure.
- Read/write collision: the RAM returns old data when the same index is read and written in the same cycle. Behaviour for this case is defined under Optional Feature.

Optional Feature:
- Macro: ZAP_BP_WRITE_BYPASS_EN.
- Defined: when o_ram_wr_en = 1 and o_ram_wr_addr equals the index read in the same cycle, that write's data is registered and replaces i_ram_rd_data at the aligned prediction cycle. Applies to clear-sequencer writes as well.
- Undefined: no bypass; the prediction shows the pre-write (stale) counter.

Test Plan:
- Reset, N=64 -> o_busy = 1 for 64 cycles; writes to indices 0..63 with data 00; then o_busy = 0; no o_pred_valid while busy.
- After clear, fetch pc=0x100 -> o_ram_rd_addr = 0x00 (0x100[7:2]); next cycle o_pred_valid = 1, o_pred_state = 00, o_pred_taken = 0.
- Resolve pc=0x104 taken with state 00, then 01, 10, 11 -> writes to idx 1 with data 01, 10, 11, 11. Resolve not taken with state 00 -> data 00.
- Fetch pc=0x104 with stall held 3 cycles -> o_ram_rd_addr = 1 and o_pred_state stable for all 3 cycles.
- Resolve pc=0x108 taken with state 01 while fetching pc=0x108 in the write cycle -> with ZAP_BP_WRITE_BYPASS_EN, prediction = 10; without it, prediction = old RAM value.
- i_clear in RUN together with i_res_valid -> resolution dropped; o_busy = 1 next cycle; full 64-cycle clear; all entries then read 00.
